flash_rom_arbiter: RTL and testbench
====================================

// Module: flash_rom_arbiter
// PURPOSE
//  Upstream client of the QSPI flash reader. Merges NES PRG (CPU) and CHR (PPU) ROM byte reads onto the single
//  flash byte port (ready / read_en / addr / rdata), adds per-port base offsets, and round-robins between ports.
//  Each port keeps a one-entry last-byte cache, so a repeated read returns without a flash access.
// PARAMETERS
//  PRG_BASE  24'h100000  flash byte offset of PRG ROM image
//  CHR_BASE  24'h140000  flash byte offset of CHR ROM image
//  PRG_AW    15          PRG address width
//  CHR_AW    13          CHR address width
// PORTS
//  clk          in   1       system clock, same clock as flash reader
//  reset        in   1       asynchronous, active-high
//  flush        in   1       invalidate both caches (mapper bank switch)
//  prg_req      in   1       PRG read request, level; hold with prg_addr stable until prg_ack
//  prg_addr     in   PRG_AW  PRG byte address
//  prg_ack      out  1       one-cycle pulse; prg_data valid in that cycle and held after it
//  prg_data     out  8       PRG read data (registered)
//  chr_req/chr_addr[CHR_AW]/chr_ack/chr_data[8]  same protocol for CHR
//  flash_ready  in   1       flash reader ready (high while idle; high for one cycle with data at end of read)
//  flash_read_en out 1       read command to flash reader
//  flash_addr   out  24      flash byte address, registered
//  flash_rdata  in   8       flash read data, valid when flash_ready rises after an access
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; both cache valid bits 0; last_grant=CHR (PRG wins first tie).
//  Address map: flash_addr = BASE + zero-extended port addr, 24-bit modulo (carry discarded, wraps at 24'hFFFFFF).
//  Cache hit: req && valid && addr==cached addr -> ack pulse + cached data on the next cycle, no flash traffic.
//   Hit served for a port in any state, unless that port owns the in-flight flash access.
//  FSM:
//   IDLE:  pending misses considered; one port -> grant it; both -> grant the port != last_grant.
//          Latch flash_addr and grant id; last_grant<=grant -> ISSUE. Miss only launched when flash_ready=1.
//   ISSUE: flash_read_en=1, held until flash_ready samples 0 (tolerates reader stalled by run_nes) -> BUSY.
//   BUSY:  flash_read_en=0; first cycle flash_ready=1: capture flash_rdata into granted port's data reg,
//          pulse its ack next cycle, write cache {addr,data,valid=1} -> IDLE.
//  Miss latency: 1 (IDLE) + ISSUE cycles + flash access + 1 capture; ack never in same cycle as req first seen.
//  Per port: at most one ack per request; ack de-asserts unconditionally after one cycle; a port cannot get
//   a hit ack and a miss ack in the same cycle (hit check excluded while that port is granted).
//  flush: clears both valid bits that cycle; if asserted at any point during ISSUE/BUSY, the in-flight
//   result is still delivered to the requester but not written to the cache. flush with hit same cycle -> miss.
//  req dropped before ack (protocol violation): access completes, cache updated, ack still pulses once.
//  Reset mid-access: immediate return to reset values; flash reader shares reset, no cleanup cycle.
//  Starvation bound: a pending miss waits at most one other-port flash access.
// STRUCTURE
//  Shared package nes_mem_pkg: state enum {IDLE,ISSUE,BUSY}, PORT_PRG/PORT_CHR ids, default base offsets.
//  Sub-module rom_port_cache (x2, parameterised on AW): holds addr/data/valid, hit output, write/flush inputs.
//  Arbiter FSM and flash interface in this module.
// TESTING
//  Bench model of flash reader: ready drops 1 cycle after read_en, returns after 11 cycles with rdata=addr[7:0]^8'hA5.
//  PRG miss addr 15'h0010 -> flash_addr 24'h100010, single read_en, prg_ack with 8'hB5; repeat -> ack next cycle, no read_en.
//  prg_req and chr_req miss same cycle after reset -> PRG served first, CHR (24'h140000+addr) second, one access each.
//  CHR miss in flight + PRG cached hit -> prg_ack within 1 cycle, chr_ack after flash completes; no extra read_en.
//  flush mid-BUSY -> in-flight ack data correct; same address re-read -> new flash access.
//  Reader stalled (ready held 1 for 20 cycles after read_en) -> read_en held 20 cycles; reset mid-BUSY -> all outputs 0, no ack.

Source files
------------

// File: rtl/nes_mem_pkg.sv
// Shared NES memory-path types: arbiter FSM states, port ids and default flash image offsets.
package nes_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      BUSY
   } arb_state_t;

   typedef enum logic {
      PORT_PRG = 1'b0,
      PORT_CHR = 1'b1
   } port_id_t;

   localparam logic [23:0] DEF_PRG_BASE = 24'h100000;
   localparam logic [23:0] DEF_CHR_BASE = 24'h140000;

endpackage

// File: rtl/rom_port_cache.sv
// One-entry last-byte cache for a single ROM port; flush has priority over a same-cycle write.
module rom_port_cache #(
   parameter int unsigned AW = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] lookup_addr,
   output logic          hit,
   output logic [7:0]    rd_data
);

   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;

   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (wr_en) begin
         addr_d  = wr_addr;
         data_d  = wr_data;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign hit     = valid_q && (addr_q == lookup_addr) && !flush;
   assign rd_data = data_q;

endmodule

// File: rtl/flash_rom_arbiter.sv
// Merges PRG and CHR ROM byte reads onto the flash reader byte port with round-robin arbitration
// and a one-entry cache per port.
module flash_rom_arbiter
   import nes_mem_pkg::*;
#(
   parameter logic [23:0] PRG_BASE = DEF_PRG_BASE,
   parameter logic [23:0] CHR_BASE = DEF_CHR_BASE,
   parameter int unsigned PRG_AW   = 15,
   parameter int unsigned CHR_AW   = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              prg_req,
   input  logic [PRG_AW-1:0] prg_addr,
   output logic              prg_ack,
   output logic [7:0]        prg_data,
   input  logic              chr_req,
   input  logic [CHR_AW-1:0] chr_addr,
   output logic              chr_ack,
   output logic [7:0]        chr_data,
   input  logic              flash_ready,
   output logic              flash_read_en,
   output logic [23:0]       flash_addr,
   input  logic [7:0]        flash_rdata
);

   localparam int unsigned MAW = (PRG_AW > CHR_AW) ? PRG_AW : CHR_AW;

   arb_state_t     state_q, state_d;
   port_id_t       grant_q, grant_d;
   port_id_t       last_q, last_d;
   port_id_t       pick;
   logic [23:0]    flash_addr_q, flash_addr_d;
   logic [MAW-1:0] miss_addr_q, miss_addr_d;
   logic           flush_seen_q, flush_seen_d;
   logic           prg_ack_q, prg_ack_d, chr_ack_q, chr_ack_d;
   logic [7:0]     prg_data_q, prg_data_d, chr_data_q, chr_data_d;

   logic           prg_hit_raw, chr_hit_raw;
   logic [7:0]     prg_cache_data, chr_cache_data;
   logic           prg_wr, chr_wr;
   logic           prg_own, chr_own, prg_hit, chr_hit, prg_pend, chr_pend;

   rom_port_cache #(.AW(PRG_AW)) u_prg_cache (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .wr_en       (prg_wr),
      .wr_addr     (miss_addr_q[PRG_AW-1:0]),
      .wr_data     (flash_rdata),
      .lookup_addr (prg_addr),
      .hit         (prg_hit_raw),
      .rd_data     (prg_cache_data)
   );

   rom_port_cache #(.AW(CHR_AW)) u_chr_cache (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .wr_en       (chr_wr),
      .wr_addr     (miss_addr_q[CHR_AW-1:0]),
      .wr_data     (flash_rdata),
      .lookup_addr (chr_addr),
      .hit         (chr_hit_raw),
      .rd_data     (chr_cache_data)
   );

   // A port whose ack is already out is not re-served, so a held request cannot double-ack.
   assign prg_own  = (state_q != IDLE) && (grant_q == PORT_PRG);
   assign chr_own  = (state_q != IDLE) && (grant_q == PORT_CHR);
   assign prg_hit  = prg_req && !prg_ack_q && prg_hit_raw && !prg_own;
   assign chr_hit  = chr_req && !chr_ack_q && chr_hit_raw && !chr_own;
   assign prg_pend = prg_req && !prg_ack_q && !prg_hit_raw;
   assign chr_pend = chr_req && !chr_ack_q && !chr_hit_raw;

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_d        = last_q;
      pick          = PORT_PRG;
      flash_addr_d  = flash_addr_q;
      miss_addr_d   = miss_addr_q;
      flush_seen_d  = flush_seen_q;
      prg_ack_d     = 1'b0;
      chr_ack_d     = 1'b0;
      prg_data_d    = prg_data_q;
      chr_data_d    = chr_data_q;
      prg_wr        = 1'b0;
      chr_wr        = 1'b0;
      flash_read_en = 1'b0;

      if (prg_hit) begin
         prg_ack_d  = 1'b1;
         prg_data_d = prg_cache_data;
      end
      if (chr_hit) begin
         chr_ack_d  = 1'b1;
         chr_data_d = chr_cache_data;
      end

      case (state_q)
         IDLE: begin
            if (flash_ready && (prg_pend || chr_pend)) begin
               if (prg_pend && chr_pend)
                  pick = (last_q == PORT_PRG) ? PORT_CHR : PORT_PRG;
               else
                  pick = prg_pend ? PORT_PRG : PORT_CHR;
               grant_d      = pick;
               last_d       = pick;
               flush_seen_d = 1'b0;
               state_d      = ISSUE;
               if (pick == PORT_PRG) begin
                  flash_addr_d = PRG_BASE + 24'(prg_addr);
                  miss_addr_d  = MAW'(prg_addr);
               end else begin
                  flash_addr_d = CHR_BASE + 24'(chr_addr);
                  miss_addr_d  = MAW'(chr_addr);
               end
            end
         end
         ISSUE: begin
            flash_read_en = 1'b1;
            if (flush)
               flush_seen_d = 1'b1;
            if (!flash_ready)
               state_d = BUSY;
         end
         BUSY: begin
            if (flush)
               flush_seen_d = 1'b1;
            if (flash_ready) begin
               state_d = IDLE;
               if (grant_q == PORT_PRG) begin
                  prg_ack_d  = 1'b1;
                  prg_data_d = flash_rdata;
                  prg_wr     = !(flush_seen_q || flush);
               end else begin
                  chr_ack_d  = 1'b1;
                  chr_data_d = flash_rdata;
                  chr_wr     = !(flush_seen_q || flush);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= PORT_PRG;
         last_q       <= PORT_CHR;
         flash_addr_q <= '0;
         miss_addr_q  <= '0;
         flush_seen_q <= 1'b0;
         prg_ack_q    <= 1'b0;
         chr_ack_q    <= 1'b0;
         prg_data_q   <= '0;
         chr_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_q       <= last_d;
         flash_addr_q <= flash_addr_d;
         miss_addr_q  <= miss_addr_d;
         flush_seen_q <= flush_seen_d;
         prg_ack_q    <= prg_ack_d;
         chr_ack_q    <= chr_ack_d;
         prg_data_q   <= prg_data_d;
         chr_data_q   <= chr_data_d;
      end
   end

   assign prg_ack    = prg_ack_q;
   assign prg_data   = prg_data_q;
   assign chr_ack    = chr_ack_q;
   assign chr_data   = chr_data_q;
   assign flash_addr = flash_addr_q;

endmodule

// File: tb/tb_flash_rom_arbiter.sv
// Bench for flash_rom_arbiter: flash reader model, vector table, directed corner cases and a
// randomized phase checked against a per-port last-byte cache model.
module tb_flash_rom_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        prg_req = 1'b0;
   logic [14:0] prg_addr = '0;
   logic        prg_ack;
   logic [7:0]  prg_data;
   logic        chr_req = 1'b0;
   logic [12:0] chr_addr = '0;
   logic        chr_ack;
   logic [7:0]  chr_data;
   logic        flash_ready;
   logic        flash_read_en;
   logic [23:0] flash_addr;
   logic [7:0]  flash_rdata;

   int vectors = 0;
   int miscompares = 0;

   flash_rom_arbiter #(
      .PRG_BASE (24'h100000),
      .CHR_BASE (24'h140000),
      .PRG_AW   (15),
      .CHR_AW   (13)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .prg_req       (prg_req),
      .prg_addr      (prg_addr),
      .prg_ack       (prg_ack),
      .prg_data      (prg_data),
      .chr_req       (chr_req),
      .chr_addr      (chr_addr),
      .chr_ack       (chr_ack),
      .chr_data      (chr_data),
      .flash_ready   (flash_ready),
      .flash_read_en (flash_read_en),
      .flash_addr    (flash_addr),
      .flash_rdata   (flash_rdata)
   );

   always #5 clk = ~clk;

   // Flash reader model: optional stall with ready still high, then ready low for 11 cycles,
   // then ready high with rdata = addr[7:0] ^ A5.
   int          stall_cfg = 0;
   int          fm_phase;
   int          fm_cnt;
   logic [23:0] fm_addr;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         flash_ready <= 1'b1;
         flash_rdata <= '0;
         fm_phase    <= 0;
         fm_cnt      <= 0;
         fm_addr     <= '0;
      end else begin
         case (fm_phase)
            0: if (flash_read_en) begin
                  fm_addr <= flash_addr;
                  if (stall_cfg == 0) begin
                     flash_ready <= 1'b0;
                     fm_cnt      <= 11;
                     fm_phase    <= 2;
                  end else begin
                     fm_cnt   <= stall_cfg - 1;
                     fm_phase <= 1;
                  end
               end
            1: if (fm_cnt == 0) begin
                  flash_ready <= 1'b0;
                  fm_cnt      <= 11;
                  fm_phase    <= 2;
               end else begin
                  fm_cnt <= fm_cnt - 1;
               end
            default: if (fm_cnt == 1) begin
                  flash_ready <= 1'b1;
                  flash_rdata <= fm_addr[7:0] ^ 8'hA5;
                  fm_phase    <= 0;
               end else begin
                  fm_cnt <= fm_cnt - 1;
               end
         endcase
      end
   end

   // Monitors: flash launches (with address log), read_en-high cycles, ack pulses.
   int          acc_cnt = 0;
   int          re_cycles = 0;
   int          prg_ack_cnt = 0;
   int          chr_ack_cnt = 0;
   logic        re_prev = 1'b0;
   logic [23:0] launch_log [256];

   always @(posedge clk) begin
      re_prev <= flash_read_en;
      if (flash_read_en) re_cycles <= re_cycles + 1;
      if (flash_read_en && !re_prev) begin
         launch_log[acc_cnt % 256] <= flash_addr;
         acc_cnt <= acc_cnt + 1;
      end
      if (prg_ack) prg_ack_cnt <= prg_ack_cnt + 1;
      if (chr_ack) chr_ack_cnt <= chr_ack_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] flash_byte(input logic [23:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   function automatic logic [23:0] prg_map(input logic [14:0] a);
      return 24'h100000 + {9'd0, a};
   endfunction

   function automatic logic [23:0] chr_map(input logic [12:0] a);
      return 24'h140000 + {11'd0, a};
   endfunction

   task automatic flush_pulse();
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
   endtask

   task automatic wait_ready_low(input string name);
      int n = 0;
      while (flash_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, flash_ready}, 32'd0);
   endtask

   task automatic run_txn(input logic pr, input logic [14:0] pa, input logic cr,
                          input logic [12:0] ca, input int cdly,
                          output logic [7:0] pd, output logic [7:0] cd,
                          output int acc, output int first_idx);
      int  a0 = acc_cnt;
      int  pa0 = prg_ack_cnt;
      int  ca0 = chr_ack_cnt;
      bit  pdone = !pr;
      bit  cdone = !cr;
      bit  tmo = 1'b0;
      int  cyc = 0;
      pd = '0;
      cd = '0;
      first_idx = a0;
      @(negedge clk);
      prg_req  = pr;
      prg_addr = pa;
      chr_addr = ca;
      if (cdly == 0) chr_req = cr;
      while (!(pdone && cdone)) begin
         @(negedge clk);
         cyc++;
         if (prg_ack && prg_req) begin pd = prg_data; pdone = 1'b1; prg_req = 1'b0; end
         if (chr_ack && chr_req) begin cd = chr_data; cdone = 1'b1; chr_req = 1'b0; end
         if (cr && !cdone && cyc == cdly) chr_req = 1'b1;
         if (cyc >= 60) begin tmo = 1'b1; break; end
      end
      prg_req = 1'b0;
      chr_req = 1'b0;
      repeat (3) @(negedge clk);
      acc = acc_cnt - a0;
      check("ack_timeout", {31'd0, tmo}, 32'd0);
      check("prg_ack_once", prg_ack_cnt - pa0, {31'd0, pr});
      check("chr_ack_once", chr_ack_cnt - ca0, {31'd0, cr});
   endtask

   typedef struct {
      logic        pr;
      logic [14:0] pa;
      logic        cr;
      logic [12:0] ca;
      logic        fl;
      logic [7:0]  exp_pd;
      logic [7:0]  exp_cd;
      int          exp_acc;
      logic [23:0] exp_a0;
      logic [23:0] exp_a1;
   } vec_t;

   vec_t vt [10];

   initial begin
      logic [7:0]  pd, cd;
      int          acc, fidx, n, c0, re0, pc0;
      logic        mp_v, mc_v;
      logic [14:0] mp_a;
      logic [12:0] mc_a;

      vt[0] = '{1'b1, 15'h0010, 1'b1, 13'h0003, 1'b0, 8'hB5, 8'hA6, 2, 24'h100010, 24'h140003};
      vt[1] = '{1'b1, 15'h0010, 1'b0, 13'h0000, 1'b0, 8'hB5, 8'h00, 0, 24'h0,      24'h0};
      vt[2] = '{1'b0, 15'h0000, 1'b1, 13'h0003, 1'b0, 8'h00, 8'hA6, 0, 24'h0,      24'h0};
      vt[3] = '{1'b1, 15'h0010, 1'b1, 13'h0003, 1'b0, 8'hB5, 8'hA6, 0, 24'h0,      24'h0};
      vt[4] = '{1'b1, 15'h0010, 1'b0, 13'h0000, 1'b1, 8'hB5, 8'h00, 1, 24'h100010, 24'h0};
      vt[5] = '{1'b1, 15'h7FFF, 1'b0, 13'h0000, 1'b0, 8'h5A, 8'h00, 1, 24'h107FFF, 24'h0};
      vt[6] = '{1'b0, 15'h0000, 1'b1, 13'h1FFF, 1'b0, 8'h00, 8'h5A, 1, 24'h141FFF, 24'h0};
      vt[7] = '{1'b1, 15'h0100, 1'b1, 13'h0100, 1'b0, 8'hA5, 8'hA5, 2, 24'h100100, 24'h140100};
      vt[8] = '{1'b1, 15'h0200, 1'b0, 13'h0000, 1'b0, 8'hA5, 8'h00, 1, 24'h100200, 24'h0};
      vt[9] = '{1'b1, 15'h0300, 1'b1, 13'h0300, 1'b0, 8'hA5, 8'hA5, 2, 24'h140300, 24'h100300};

      repeat (3) @(negedge clk);
      check("reset_outputs", {12'd0, prg_ack, chr_ack, flash_read_en, prg_data, chr_data, 1'b0},
            32'd0);
      check("reset_flash_addr", {8'd0, flash_addr}, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int unsigned i = 0; i < 10; i++) begin
         if (vt[i].fl) flush_pulse();
         run_txn(vt[i].pr, vt[i].pa, vt[i].cr, vt[i].ca, 0, pd, cd, acc, fidx);
         if (vt[i].pr) check($sformatf("vec%0d_prg_data", i), {24'd0, pd}, {24'd0, vt[i].exp_pd});
         if (vt[i].cr) check($sformatf("vec%0d_chr_data", i), {24'd0, cd}, {24'd0, vt[i].exp_cd});
         check($sformatf("vec%0d_accesses", i), acc, vt[i].exp_acc);
         if (vt[i].exp_acc >= 1)
            check($sformatf("vec%0d_addr0", i), {8'd0, launch_log[fidx % 256]}, {8'd0, vt[i].exp_a0});
         if (vt[i].exp_acc >= 2)
            check($sformatf("vec%0d_addr1", i), {8'd0, launch_log[(fidx + 1) % 256]},
                  {8'd0, vt[i].exp_a1});
      end

      // Cached hit acks on the very next cycle.
      c0 = acc_cnt;
      @(negedge clk); prg_req = 1'b1; prg_addr = 15'h0300;
      @(negedge clk);
      check("hit_latency", {31'd0, prg_ack}, 32'd1);
      check("hit_data", {24'd0, prg_data}, 32'hA5);
      prg_req = 1'b0;
      repeat (3) @(negedge clk);
      check("hit_no_access", acc_cnt - c0, 32'd0);

      // CHR miss in flight while PRG hits.
      c0 = acc_cnt;
      @(negedge clk); chr_req = 1'b1; chr_addr = 13'h0444;
      wait_ready_low("chr_inflight_started");
      prg_req = 1'b1; prg_addr = 15'h0300;
      @(negedge clk);
      check("inflight_prg_hit", {31'd0, prg_ack}, 32'd1);
      check("inflight_prg_data", {24'd0, prg_data}, 32'hA5);
      prg_req = 1'b0;
      n = 0;
      while (!chr_ack && n < 40) begin @(negedge clk); n++; end
      check("inflight_chr_ack", {31'd0, chr_ack}, 32'd1);
      check("inflight_chr_data", {24'd0, chr_data}, 32'hE1);
      chr_req = 1'b0;
      repeat (3) @(negedge clk);
      check("inflight_accesses", acc_cnt - c0, 32'd1);

      // Flush during BUSY: result delivered but not cached.
      @(negedge clk); prg_req = 1'b1; prg_addr = 15'h0020;
      wait_ready_low("flush_busy_started");
      repeat (2) @(negedge clk);
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      n = 0;
      while (!prg_ack && n < 40) begin @(negedge clk); n++; end
      check("flush_inflight_ack", {31'd0, prg_ack}, 32'd1);
      check("flush_inflight_data", {24'd0, prg_data}, 32'h85);
      prg_req = 1'b0;
      repeat (3) @(negedge clk);
      run_txn(1'b1, 15'h0020, 1'b0, 13'h0, 0, pd, cd, acc, fidx);
      check("flush_reread_access", acc, 32'd1);
      check("flush_reread_data", {24'd0, pd}, 32'h85);

      // Reader stalled with ready held high.
      stall_cfg = 20;
      re0 = re_cycles;
      run_txn(1'b1, 15'h0030, 1'b0, 13'h0, 0, pd, cd, acc, fidx);
      check("stall_read_en_held", {31'd0, (re_cycles - re0) >= 20}, 32'd1);
      check("stall_data", {24'd0, pd}, 32'h95);
      check("stall_accesses", acc, 32'd1);
      stall_cfg = 0;

      // Reset during BUSY.
      @(negedge clk); prg_req = 1'b1; prg_addr = 15'h0040;
      wait_ready_low("reset_busy_started");
      @(negedge clk);
      reset = 1'b1; prg_req = 1'b0;
      #1;
      check("midreset_outputs", {12'd0, prg_ack, chr_ack, flash_read_en, prg_data, chr_data, 1'b0},
            32'd0);
      check("midreset_flash_addr", {8'd0, flash_addr}, 32'd0);
      repeat (2) @(negedge clk);
      pc0 = prg_ack_cnt;
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check("midreset_no_ack", prg_ack_cnt - pc0, 32'd0);
      run_txn(1'b1, 15'h0030, 1'b0, 13'h0, 0, pd, cd, acc, fidx);
      check("postreset_cache_cleared", acc, 32'd1);
      check("postreset_data", {24'd0, pd}, 32'h95);

      // Randomized: each port's cache holds the last address it completed, flush empties both.
      mp_v = 1'b1; mp_a = 15'h0030;
      mc_v = 1'b0; mc_a = '0;
      for (int unsigned it = 0; it < 150; it++) begin
         logic        pr, cr;
         logic [14:0] pa;
         logic [12:0] ca;
         int          exp_acc, cdly;
         logic [14:0] ppool [4];
         logic [12:0] cpool [4];
         ppool = '{15'h0010, 15'h0011, 15'h7FFF, 15'h4000};
         cpool = '{13'h0003, 13'h1FFF, 13'h0100, 13'h0ABC};
         pr = 1'($urandom_range(0, 1));
         cr = 1'($urandom_range(0, 1));
         if (!pr && !cr) pr = 1'b1;
         pa = ppool[$urandom_range(0, 3)];
         ca = cpool[$urandom_range(0, 3)];
         cdly = $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) begin
            flush_pulse();
            mp_v = 1'b0;
            mc_v = 1'b0;
         end
         exp_acc = 0;
         if (pr && !(mp_v && mp_a == pa)) exp_acc++;
         if (cr && !(mc_v && mc_a == ca)) exp_acc++;
         run_txn(pr, pa, cr, ca, cdly, pd, cd, acc, fidx);
         if (pr) check("rand_prg_data", {24'd0, pd}, {24'd0, flash_byte(prg_map(pa))});
         if (cr) check("rand_chr_data", {24'd0, cd}, {24'd0, flash_byte(chr_map(ca))});
         check("rand_accesses", acc, exp_acc);
         if (pr) begin mp_v = 1'b1; mp_a = pa; end
         if (cr) begin mc_v = 1'b1; mc_a = ca; end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
